// File: rtl/audio_mix.sv
// Stereo mixer: per-source gain, saturating sum and a slew-limited speaker level.
// Clip flags are stretched by a per-channel hold counter so they can drive LEDs.
module audio_mix #(
    parameter int SPK_STEP         = 64,
    parameter int CLIP_HOLD_CYCLES = 2_700_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_stb_i,
    input  logic [15:0] ssp_audio_i,
    input  logic [9:0]  mb_audio_l_i,
    input  logic [9:0]  mb_audio_r_i,
    input  logic        speaker_i,
    input  logic [3:0]  gain_ssp_i,
    input  logic [3:0]  gain_mb_i,
    input  logic [3:0]  gain_spk_i,
    input  logic        mute_i,
    output logic [15:0] audio_l_o,
    output logic [15:0] audio_r_o,
    output logic        out_valid_o,
    output logic        clip_l_o,
    output logic        clip_r_o
);

    localparam int               CNT_W     = (CLIP_HOLD_CYCLES > 1) ? $clog2(CLIP_HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(CLIP_HOLD_CYCLES);
    localparam logic [12:0]      STEP13    = 13'(SPK_STEP);
    localparam logic [13:0]      SPK_FULL  = 14'd8191;

    logic [12:0] spk_lvl_r;
    logic [12:0] spk_lvl_nxt_s;
    logic [13:0] spk_up_s;

    logic        s1_valid_r;
    logic        s1_mute_r;
    logic [15:0] s1_ssp_r;
    logic [14:0] s1_ml_r;
    logic [14:0] s1_mr_r;
    logic [12:0] s1_spk_r;
    logic [3:0]  s1_gain_ssp_r;
    logic [3:0]  s1_gain_mb_r;
    logic [3:0]  s1_gain_spk_r;

    logic [19:0] prod_ssp_s;
    logic [18:0] prod_ml_s;
    logic [18:0] prod_mr_s;
    logic [16:0] prod_spk_s;
    logic        unused_frac_s;

    logic        s2_valid_r;
    logic        s2_mute_r;
    logic [16:0] s2_ssp_r;
    logic [15:0] s2_ml_r;
    logic [15:0] s2_mr_r;
    logic [13:0] s2_spk_r;

    logic [17:0] sum_l_s;
    logic [17:0] sum_r_s;
    logic [15:0] mix_l_s;
    logic [15:0] mix_r_s;
    logic        clip_evt_l_s;
    logic        clip_evt_r_s;
    logic [CNT_W-1:0] clip_cnt_l_r;
    logic [CNT_W-1:0] clip_cnt_r_r;
    logic [CNT_W-1:0] clip_cnt_l_nxt_s;
    logic [CNT_W-1:0] clip_cnt_r_nxt_s;

    logic [15:0] audio_l_r;
    logic [15:0] audio_r_r;
    logic        out_valid_r;
    logic        clip_l_r;
    logic        clip_r_r;

    assign spk_up_s = {1'b0, spk_lvl_r} + {1'b0, STEP13};

    // Speaker level moves toward its rail by one step, clamped at the rail.
    always_comb begin
        spk_lvl_nxt_s = spk_lvl_r;
        if (speaker_i) begin
            if (spk_up_s >= SPK_FULL) begin
                spk_lvl_nxt_s = 13'h1FFF;
            end else begin
                spk_lvl_nxt_s = spk_up_s[12:0];
            end
        end else begin
            if (spk_lvl_r <= STEP13) begin
                spk_lvl_nxt_s = 13'd0;
            end else begin
                spk_lvl_nxt_s = spk_lvl_r - STEP13;
            end
        end
    end

    // Speaker level register, free-running independent of the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spk_lvl_r <= 13'd0;
        end else begin
            spk_lvl_r <= spk_lvl_nxt_s;
        end
    end

    // Stage 1: capture sources and gains; the speaker level is the pre-update value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r    <= 1'b0;
            s1_mute_r     <= 1'b0;
            s1_ssp_r      <= 16'd0;
            s1_ml_r       <= 15'd0;
            s1_mr_r       <= 15'd0;
            s1_spk_r      <= 13'd0;
            s1_gain_ssp_r <= 4'd0;
            s1_gain_mb_r  <= 4'd0;
            s1_gain_spk_r <= 4'd0;
        end else begin
            s1_valid_r <= sample_stb_i;
            if (sample_stb_i) begin
                s1_mute_r     <= mute_i;
                s1_ssp_r      <= ssp_audio_i;
                s1_ml_r       <= {mb_audio_l_i, 5'b00000};
                s1_mr_r       <= {mb_audio_r_i, 5'b00000};
                s1_spk_r      <= spk_lvl_r;
                s1_gain_ssp_r <= gain_ssp_i;
                s1_gain_mb_r  <= gain_mb_i;
                s1_gain_spk_r <= gain_spk_i;
            end
        end
    end

    // Full-width products; gains are in eighths so the low three bits are dropped.
    assign prod_ssp_s    = 20'(s1_ssp_r) * 20'(s1_gain_ssp_r);
    assign prod_ml_s     = 19'(s1_ml_r) * 19'(s1_gain_mb_r);
    assign prod_mr_s     = 19'(s1_mr_r) * 19'(s1_gain_mb_r);
    assign prod_spk_s    = 17'(s1_spk_r) * 17'(s1_gain_spk_r);
    assign unused_frac_s = ^{prod_ssp_s[2:0], prod_ml_s[2:0], prod_mr_s[2:0], prod_spk_s[2:0]};

    // Stage 2: register the scaled sources.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_r <= 1'b0;
            s2_mute_r  <= 1'b0;
            s2_ssp_r   <= 17'd0;
            s2_ml_r    <= 16'd0;
            s2_mr_r    <= 16'd0;
            s2_spk_r   <= 14'd0;
        end else begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_mute_r <= s1_mute_r;
                s2_ssp_r  <= prod_ssp_s[19:3];
                s2_ml_r   <= prod_ml_s[18:3];
                s2_mr_r   <= prod_mr_s[18:3];
                s2_spk_r  <= prod_spk_s[16:3];
            end
        end
    end

    assign sum_l_s = 18'(s2_ssp_r) + 18'(s2_ml_r) + 18'(s2_spk_r);
    assign sum_r_s = 18'(s2_ssp_r) + 18'(s2_mr_r) + 18'(s2_spk_r);

    // Stage 3 mix: mute wins, otherwise saturate at full scale and flag the clip.
    always_comb begin
        mix_l_s      = sum_l_s[15:0];
        mix_r_s      = sum_r_s[15:0];
        clip_evt_l_s = 1'b0;
        clip_evt_r_s = 1'b0;
        if (s2_mute_r) begin
            mix_l_s = 16'h0000;
            mix_r_s = 16'h0000;
        end else begin
            if (sum_l_s > 18'h0FFFF) begin
                mix_l_s      = 16'hFFFF;
                clip_evt_l_s = 1'b1;
            end else begin
                mix_l_s = sum_l_s[15:0];
            end
            if (sum_r_s > 18'h0FFFF) begin
                mix_r_s      = 16'hFFFF;
                clip_evt_r_s = 1'b1;
            end else begin
                mix_r_s = sum_r_s[15:0];
            end
        end
    end

    // Hold counters reload on a clip from a valid sample, otherwise count down to zero.
    always_comb begin
        clip_cnt_l_nxt_s = clip_cnt_l_r;
        clip_cnt_r_nxt_s = clip_cnt_r_r;
        if (s2_valid_r && clip_evt_l_s) begin
            clip_cnt_l_nxt_s = HOLD_LOAD;
        end else if (clip_cnt_l_r != {CNT_W{1'b0}}) begin
            clip_cnt_l_nxt_s = clip_cnt_l_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            clip_cnt_l_nxt_s = {CNT_W{1'b0}};
        end
        if (s2_valid_r && clip_evt_r_s) begin
            clip_cnt_r_nxt_s = HOLD_LOAD;
        end else if (clip_cnt_r_r != {CNT_W{1'b0}}) begin
            clip_cnt_r_nxt_s = clip_cnt_r_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            clip_cnt_r_nxt_s = {CNT_W{1'b0}};
        end
    end

    // Stage 3 output registers; clip flags track the counters' next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            audio_l_r    <= 16'd0;
            audio_r_r    <= 16'd0;
            out_valid_r  <= 1'b0;
            clip_l_r     <= 1'b0;
            clip_r_r     <= 1'b0;
            clip_cnt_l_r <= {CNT_W{1'b0}};
            clip_cnt_r_r <= {CNT_W{1'b0}};
        end else begin
            out_valid_r  <= s2_valid_r;
            clip_cnt_l_r <= clip_cnt_l_nxt_s;
            clip_cnt_r_r <= clip_cnt_r_nxt_s;
            clip_l_r     <= (clip_cnt_l_nxt_s != {CNT_W{1'b0}});
            clip_r_r     <= (clip_cnt_r_nxt_s != {CNT_W{1'b0}});
            if (s2_valid_r) begin
                audio_l_r <= mix_l_s;
                audio_r_r <= mix_r_s;
            end
        end
    end

    assign audio_l_o   = audio_l_r;
    assign audio_r_o   = audio_r_r;
    assign out_valid_o = out_valid_r;
    assign clip_l_o    = clip_l_r;
    assign clip_r_o    = clip_r_r;

endmodule

// File: tb/tb_audio_mix.sv
// Bench for audio_mix: directed scenarios plus random traffic, all checked
// against an arithmetic reference model of the mixer rules.
module tb_audio_mix;

    localparam int STEP = 64;
    localparam int HOLD = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_stb_i;
    logic [15:0] ssp_audio_i;
    logic [9:0]  mb_audio_l_i;
    logic [9:0]  mb_audio_r_i;
    logic        speaker_i;
    logic [3:0]  gain_ssp_i;
    logic [3:0]  gain_mb_i;
    logic [3:0]  gain_spk_i;
    logic        mute_i;
    logic [15:0] audio_l_o;
    logic [15:0] audio_r_o;
    logic        out_valid_o;
    logic        clip_l_o;
    logic        clip_r_o;

    always #5 clk = ~clk;

    audio_mix #(.SPK_STEP(STEP), .CLIP_HOLD_CYCLES(HOLD)) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_stb_i(sample_stb_i),
        .ssp_audio_i (ssp_audio_i),
        .mb_audio_l_i(mb_audio_l_i),
        .mb_audio_r_i(mb_audio_r_i),
        .speaker_i   (speaker_i),
        .gain_ssp_i  (gain_ssp_i),
        .gain_mb_i   (gain_mb_i),
        .gain_spk_i  (gain_spk_i),
        .mute_i      (mute_i),
        .audio_l_o   (audio_l_o),
        .audio_r_o   (audio_r_o),
        .out_valid_o (out_valid_o),
        .clip_l_o    (clip_l_o),
        .clip_r_o    (clip_r_o)
    );

    typedef struct {
        int due;
        int l;
        int r;
        bit cl;
        bit cr;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cycle   = 0;
    int   lvl, cnt_l, cnt_r, exp_l, exp_r;
    bit   exp_valid, exp_cl, exp_cr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Expected mix of the inputs currently presented, using the model speaker level.
    function automatic exp_t mix(input int due);
        exp_t e;
        int s, ml, mr, k, sl, sr;
        s  = (int'(ssp_audio_i) * int'(gain_ssp_i)) / 8;
        ml = (int'(mb_audio_l_i) * 32 * int'(gain_mb_i)) / 8;
        mr = (int'(mb_audio_r_i) * 32 * int'(gain_mb_i)) / 8;
        k  = (lvl * int'(gain_spk_i)) / 8;
        sl = s + ml + k;
        sr = s + mr + k;
        e.due = due;
        if (mute_i) begin
            e.l = 0; e.r = 0; e.cl = 0; e.cr = 0;
        end else begin
            e.cl = (sl > 65535);
            e.cr = (sr > 65535);
            e.l  = e.cl ? 65535 : sl;
            e.r  = e.cr ? 65535 : sr;
        end
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        lvl = 0; cnt_l = 0; cnt_r = 0; exp_l = 0; exp_r = 0;
        exp_valid = 0; exp_cl = 0; exp_cr = 0;
    endtask

    task automatic check_all();
        chk("valid",  out_valid_o, exp_valid);
        chk("audio_l", audio_l_o, exp_l);
        chk("audio_r", audio_r_o, exp_r);
        chk("clip_l", clip_l_o, exp_cl);
        chk("clip_r", clip_r_o, exp_cr);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            cycle++;
            if (sample_stb_i) q.push_back(mix(cycle + 2));
            if (speaker_i) lvl = (lvl + STEP > 8191) ? 8191 : lvl + STEP;
            else           lvl = (lvl - STEP < 0) ? 0 : lvl - STEP;
            exp_valid = 0;
            if (q.size() > 0 && q[0].due == cycle) begin
                e = q.pop_front();
                exp_valid = 1;
                exp_l = e.l;
                exp_r = e.r;
                cnt_l = e.cl ? HOLD : ((cnt_l > 0) ? cnt_l - 1 : 0);
                cnt_r = e.cr ? HOLD : ((cnt_r > 0) ? cnt_r - 1 : 0);
            end else begin
                cnt_l = (cnt_l > 0) ? cnt_l - 1 : 0;
                cnt_r = (cnt_r > 0) ? cnt_r - 1 : 0;
            end
            exp_cl = (cnt_l != 0);
            exp_cr = (cnt_r != 0);
        end
        #1;
        check_all();
    endtask

    task automatic set_src(input int s, input int ml, input int mr);
        ssp_audio_i  = 16'(s);
        mb_audio_l_i = 10'(ml);
        mb_audio_r_i = 10'(mr);
    endtask

    initial begin
        int n, v1;
        model_reset();
        reset = 1'b1; sample_stb_i = 1'b0; speaker_i = 1'b0; mute_i = 1'b0;
        set_src(0, 0, 0);
        gain_ssp_i = 4'd8; gain_mb_i = 4'd8; gain_spk_i = 4'd8;
        tick(); tick();
        chk("rst_audio_l", audio_l_o, 16'h0000);
        chk("rst_valid", out_valid_o, 1'b0);
        reset = 1'b0;

        // Unity mix and latency with speaker at full scale
        speaker_i = 1'b1;
        repeat (140) tick();
        set_src(16'h1000, 10'h100, 10'h080);
        sample_stb_i = 1'b1; tick();
        sample_stb_i = 1'b0;
        chk("lat_1", out_valid_o, 1'b0);
        tick();
        chk("lat_2", out_valid_o, 1'b0);
        tick();
        chk("lat_3", out_valid_o, 1'b1);
        chk("unity_l", audio_l_o, 16'h4FFF);
        chk("unity_r", audio_r_o, 16'h3FFF);
        chk("unity_noclip", clip_l_o, 1'b0);
        tick();
        chk("lat_4", out_valid_o, 1'b0);

        // Saturation and clip hold
        speaker_i = 1'b0;
        repeat (140) tick();
        set_src(16'hF000, 10'h3FF, 0);
        sample_stb_i = 1'b1; tick();
        sample_stb_i = 1'b0; tick(); tick();
        chk("sat_l", audio_l_o, 16'hFFFF);
        chk("sat_r", audio_r_o, 16'hF000);
        chk("sat_clip_l", clip_l_o, 1'b1);
        chk("sat_clip_r", clip_r_o, 1'b0);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (clip_l_o) n++;
            else break;
        end
        chk("clip_hold_len", n, HOLD);

        // Gain math
        set_src(16'h1000, 0, 0);
        gain_ssp_i = 4'd15;
        sample_stb_i = 1'b1; tick();
        sample_stb_i = 1'b0; tick(); tick();
        chk("gain15", audio_l_o, 16'h1E00);
        gain_ssp_i = 4'd0;
        sample_stb_i = 1'b1; tick();
        sample_stb_i = 1'b0; tick(); tick();
        chk("gain0", audio_l_o, 16'h0000);

        // Speaker slew with g_spk = 1 so a full step shows as 8 LSBs
        gain_ssp_i = 4'd8; gain_spk_i = 4'd1;
        set_src(0, 0, 0);
        sample_stb_i = 1'b1; speaker_i = 1'b1;
        repeat (135) tick();
        chk("slew_top", audio_l_o, 16'h03FF);
        tick();
        chk("slew_hold", audio_l_o, 16'h03FF);
        speaker_i = 1'b0;
        repeat (140) tick();
        speaker_i = 1'b1;
        repeat (40) tick();
        speaker_i = 1'b0;
        repeat (6) tick();
        v1 = int'(audio_l_o);
        tick();
        chk("slew_reverse", audio_l_o, 32'(v1 - 8));
        sample_stb_i = 1'b0;

        // Mute with overflowing inputs
        mute_i = 1'b1; gain_ssp_i = 4'd15; gain_mb_i = 4'd15;
        set_src(16'hFFFF, 10'h3FF, 10'h3FF);
        sample_stb_i = 1'b1; tick();
        sample_stb_i = 1'b0; tick(); tick();
        chk("mute_valid", out_valid_o, 1'b1);
        chk("mute_l", audio_l_o, 16'h0000);
        chk("mute_clip", clip_l_o, 1'b0);
        mute_i = 1'b0;

        // Reset mid-pipeline after a clipping sample
        gain_ssp_i = 4'd8; gain_mb_i = 4'd8; gain_spk_i = 4'd8; speaker_i = 1'b1;
        set_src(16'hF000, 10'h3FF, 10'h3FF);
        sample_stb_i = 1'b1; tick();
        sample_stb_i = 1'b0; tick(); tick();
        chk("pre_rst_l", audio_l_o, 16'hFFFF);
        sample_stb_i = 1'b1; tick(); tick();
        sample_stb_i = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("arst_l", audio_l_o, 16'h0000);
        chk("arst_r", audio_r_o, 16'h0000);
        chk("arst_valid", out_valid_o, 1'b0);
        chk("arst_clip_l", clip_l_o, 1'b0);
        chk("arst_clip_r", clip_r_o, 1'b0);
        tick();
        reset = 1'b0;
        set_src(0, 0, 0);
        sample_stb_i = 1'b1; tick();
        sample_stb_i = 1'b0;
        chk("post_rst_novalid", out_valid_o, 1'b0);
        tick(); tick();
        chk("post_rst_valid", out_valid_o, 1'b1);
        chk("spk_restart", audio_l_o, 16'h0000);
        repeat (5) tick();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            sample_stb_i = ($urandom_range(0, 9) < 7);
            set_src(int'($urandom_range(0, 65535)), int'($urandom_range(0, 1023)),
                    int'($urandom_range(0, 1023)));
            gain_ssp_i = 4'($urandom_range(0, 15));
            gain_mb_i  = 4'($urandom_range(0, 15));
            gain_spk_i = 4'($urandom_range(0, 15));
            mute_i     = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) speaker_i = ~speaker_i;
            tick();
        end
        sample_stb_i = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
